// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Latency: none (types, constants and a helper function only).
// Backpressure: not applicable.
// Contents: FSM state encoding, starvation limit default, starvation counter width.
package mem_arb_pkg;

   localparam int STARVE_LIMIT_DEF = 4;
   localparam int STARVE_W         = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE_I = 3'd1,
      ST_ISSUE_D = 3'd2,
      ST_WAIT_I  = 3'd3,
      ST_WAIT_D  = 3'd4
   } arb_state_t;

   // Saturating increment for the starvation counter.
   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
      return (&v) ? v : v + STARVE_W'(1);
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requesters: data first, fetch on starvation.
// Latency: purely combinational.
// Backpressure: none; the caller only acts on the grant while idle.
// Ports: i_rd, d_rd, d_wr request lines; starve_cnt consecutive data grants
//        seen while a fetch waits; grant_i / grant_d one-hot (or both low).
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                i_rd,
   input  logic                d_rd,
   input  logic                d_wr,
   input  logic [STARVE_W-1:0] starve_cnt,
   output logic                grant_i,
   output logic                grant_d
);

   logic d_req;
   logic starved;

   assign d_req   = d_rd | d_wr;
   // A waiting fetch that has already lost STARVE_LIMIT times in a row takes this slot.
   assign starved = i_rd && (starve_cnt == STARVE_W'(STARVE_LIMIT));
   assign grant_d = d_req && !starved;
   assign grant_i = i_rd && !grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one stalling memory port.
// Latency: grant in IDLE, request on the next cycle; best-case completion one cycle after the request.
// Backpressure: x_stall holds each requester until its x_done; memory stalls via m_stall/m_done.
// Ports: clk/rst (async active-low); i_* fetch side; d_* data side;
//        m_* shared memory request/response; err sticky error flag.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rd,
   input  logic [15:0] i_addr,
   output logic [15:0] i_rdata,
   output logic        i_done,
   output logic        i_stall,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_done,
   output logic        d_stall,
   output logic [15:0] m_addr,
   output logic [15:0] m_wdata,
   output logic        m_rd,
   output logic        m_wr,
   input  logic [15:0] m_rdata,
   input  logic        m_done,
   input  logic        m_stall,
   input  logic        m_cachehit,
   input  logic        m_err,
   output logic        err
);

   arb_state_t          state, state_nxt;
   logic [STARVE_W-1:0] starve_cnt;
   logic                grant_i, grant_d;
   logic                idle, illegal;
   logic                i_cmpl, d_cmpl;
   logic                d_is_wr;
   logic [15:0]         i_rdata_q, d_rdata_q;
   logic                unused_dbg;

   // Cache-hit indication is observability only; nothing decides on it.
   assign unused_dbg = m_cachehit;

   mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
      .i_rd       (i_rd),
      .d_rd       (d_rd),
      .d_wr       (d_wr),
      .starve_cnt (starve_cnt),
      .grant_i    (grant_i),
      .grant_d    (grant_d)
   );

   assign idle    = (state == ST_IDLE);
   // Simultaneous read+write is rejected in place: flagged, acknowledged, never issued.
   assign illegal = idle && grant_d && d_rd && d_wr;
   assign i_cmpl  = m_done && ((state == ST_ISSUE_I) || (state == ST_WAIT_I));
   assign d_cmpl  = m_done && ((state == ST_ISSUE_D) || (state == ST_WAIT_D));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      m_rd      = 1'b0;
      m_wr      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_i)                  state_nxt = ST_ISSUE_I;
            else if (grant_d && !illegal) state_nxt = ST_ISSUE_D;
         end
         ST_ISSUE_I: begin
            m_rd = 1'b1;
            if (m_done)        state_nxt = ST_IDLE;
            else if (!m_stall) state_nxt = ST_WAIT_I;
         end
         ST_ISSUE_D: begin
            m_rd = !d_is_wr;
            m_wr = d_is_wr;
            if (m_done)        state_nxt = ST_IDLE;
            else if (!m_stall) state_nxt = ST_WAIT_D;
         end
         ST_WAIT_I: if (m_done) state_nxt = ST_IDLE;
         ST_WAIT_D: if (m_done) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_addr     <= '0;
         m_wdata    <= '0;
         d_is_wr    <= 1'b0;
         starve_cnt <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
         err        <= 1'b0;
      end else begin
         if (idle) begin
            if (grant_i) begin
               m_addr     <= i_addr;
               starve_cnt <= '0;
            end else if (grant_d) begin
               // Only count losses the fetch actually suffered.
               starve_cnt <= i_rd ? sat_inc(starve_cnt) : '0;
               if (!illegal) begin
                  m_addr  <= d_addr;
                  m_wdata <= d_wdata;
                  d_is_wr <= d_wr;
               end
            end else begin
               starve_cnt <= '0;
            end
         end
         if (i_cmpl) i_rdata_q <= m_rdata;
         if (d_cmpl) d_rdata_q <= m_rdata;
         if (illegal || (!idle && m_err)) err <= 1'b1;
      end
   end

   // Completion data is forwarded in the done cycle, then held from the register.
   assign i_done  = i_cmpl;
   assign d_done  = d_cmpl || (illegal && rst);
   assign i_rdata = i_cmpl ? m_rdata : i_rdata_q;
   assign d_rdata = d_cmpl ? m_rdata : d_rdata_q;
   assign i_stall = i_rd & ~i_done;
   assign d_stall = (d_rd | d_wr) & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized phase.
// Latency: not applicable (simulation only).
// Backpressure: the bench plays both requesters and the stalling memory.
module tb_mem_arbiter;

   localparam int LIMIT = 4;

   typedef struct packed {logic hit; logic [3:0] n; logic [3:0] w;} plan_t;
   typedef struct packed {logic [1:0] op; logic [15:0] addr; logic [15:0] wdata;} dreq_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_rd, i_done, i_stall, d_rd, d_wr, d_done, d_stall;
   logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
   logic        m_rd, m_wr, m_done, m_stall, m_cachehit, m_err, err;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
      .m_rdata(m_rdata), .m_done(m_done), .m_stall(m_stall),
      .m_cachehit(m_cachehit), .m_err(m_err), .err(err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: one access at a time, described by its memory plan.
   bit          busy, own_d, cur_wr, e_err;
   int          cyc, starve;
   plan_t       pl;
   logic [15:0] e_addr, e_wdata, e_irdata, e_drdata;
   // Requester and memory stimulus state.
   bit          i_pend, d_pend;
   dreq_t       d_cur;
   logic [15:0] i_addr_q[$];
   dreq_t       d_q[$];
   plan_t       plan_q[$];
   bit          rand_en, gap_en, stray_force, rdata_fix_en;
   logic [15:0] rdata_fix;
   // Observations of the DUT for the directed scenarios.
   int          cyc_cnt, mreq_cnt, order_n, i_req_cyc, i_done_cyc, d_req_cyc, d_done_cyc;
   logic [7:0]  order;
   bit          prev_mreq;

   function automatic plan_t next_plan();
      plan_t p;
      if (plan_q.size() > 0) return plan_q.pop_front();
      p.hit = ($urandom % 3 == 0);
      p.n   = 4'($urandom % 3);
      p.w   = 4'(1 + $urandom % 2);
      return p;
   endfunction

   task automatic step();
      bit          win_i, win_d, ill, issue, done;
      logic        e_mrd, e_mwr, ei_done, ed_done;
      logic [15:0] e_ir, e_dr;
      // Requesters: hold a request until its completion.
      if (!i_pend) begin
         if (i_addr_q.size() > 0 && (!gap_en || $urandom % 2 == 0)) begin
            i_addr = i_addr_q.pop_front(); i_pend = 1; i_req_cyc = cyc_cnt;
         end else if (rand_en && $urandom % 3 == 0) begin
            i_addr = 16'($urandom); i_pend = 1;
         end
      end
      i_rd = i_pend;
      if (!d_pend) begin
         if (d_q.size() > 0 && (!gap_en || $urandom % 2 == 0)) begin
            d_cur = d_q.pop_front(); d_pend = 1; d_req_cyc = cyc_cnt;
         end else if (rand_en && $urandom % 3 == 0) begin
            d_cur.op    = ($urandom % 10 == 0) ? 2'd2 : 2'($urandom % 2);
            d_cur.addr  = 16'($urandom);
            d_cur.wdata = 16'($urandom);
            d_pend = 1;
         end
      end
      d_rd    = d_pend && (d_cur.op != 2'd1);
      d_wr    = d_pend && (d_cur.op != 2'd0);
      d_addr  = d_cur.addr;
      d_wdata = d_cur.wdata;
      // Memory side follows the plan of the current access.
      m_rdata    = rdata_fix_en ? rdata_fix : 16'($urandom);
      m_cachehit = 1'($urandom % 2);
      m_err      = rand_en && ($urandom % 200 == 0);
      if (busy) begin
         issue   = pl.hit ? (cyc == 0) : (cyc <= int'(pl.n));
         done    = pl.hit ? (cyc == 0) : (cyc == int'(pl.n) + int'(pl.w));
         m_done  = done;
         m_stall = pl.hit ? 1'($urandom % 2) : (cyc < int'(pl.n));
      end else begin
         issue   = 0;
         done    = 0;
         m_done  = stray_force || (rand_en && $urandom % 4 == 0);
         m_stall = 1'($urandom % 2);
      end
      // Expected outputs for this cycle.
      win_i = 0; win_d = 0; ill = 0;
      if (!busy) begin
         win_i = i_pend && (!d_pend || starve == LIMIT);
         win_d = d_pend && !win_i;
         ill   = win_d && (d_cur.op == 2'd2);
      end
      e_mrd   = issue && (!own_d || !cur_wr);
      e_mwr   = issue && own_d && cur_wr;
      ei_done = done && !own_d;
      ed_done = (done && own_d) || ill;
      e_ir    = ei_done ? m_rdata : e_irdata;
      e_dr    = (done && own_d) ? m_rdata : e_drdata;
      #2;
      check("m_rd", 32'(m_rd), 32'(e_mrd));
      check("m_wr", 32'(m_wr), 32'(e_mwr));
      check("i_done", 32'(i_done), 32'(ei_done));
      check("d_done", 32'(d_done), 32'(ed_done));
      check("i_rdata", 32'(i_rdata), 32'(e_ir));
      check("d_rdata", 32'(d_rdata), 32'(e_dr));
      check("i_stall", 32'(i_stall), 32'(i_rd & ~ei_done));
      check("d_stall", 32'(d_stall), 32'((d_rd | d_wr) & ~ed_done));
      check("err", 32'(err), 32'(e_err));
      check("m_addr", 32'(m_addr), 32'(e_addr));
      check("m_wdata", 32'(m_wdata), 32'(e_wdata));
      if (m_rd || m_wr) begin
         mreq_cnt++;
         if (!prev_mreq) begin order = {order[6:0], m_wr}; order_n++; end
      end
      prev_mreq = m_rd || m_wr;
      if (i_done) i_done_cyc = cyc_cnt;
      if (d_done) d_done_cyc = cyc_cnt;
      // Advance the model to the next cycle.
      if (busy) begin
         if (m_err) e_err = 1;
         if (done) begin
            busy = 0;
            if (own_d) begin e_drdata = m_rdata; d_pend = 0; end
            else       begin e_irdata = m_rdata; i_pend = 0; end
         end else cyc++;
      end else if (win_i) begin
         busy = 1; own_d = 0; cyc = 0; pl = next_plan(); e_addr = i_addr; starve = 0;
      end else if (win_d) begin
         starve = i_pend ? ((starve < 7) ? starve + 1 : 7) : 0;
         if (ill) begin
            e_err = 1; d_pend = 0;
         end else begin
            busy = 1; own_d = 1; cyc = 0; cur_wr = (d_cur.op == 2'd1); pl = next_plan();
            e_addr = d_cur.addr; e_wdata = d_cur.wdata;
         end
      end else starve = 0;
      cyc_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int g = 0;
      while ((busy || i_pend || d_pend || i_addr_q.size() > 0 || d_q.size() > 0) && g < 300) begin
         step(); g++;
      end
      check("drain_budget", 32'(g < 300), 32'd1);
   endtask

   initial begin
      int g;
      // Reset with everything active, including an illegal data request.
      rst = 0; i_rd = 1; i_addr = 16'h0011; d_rd = 1; d_wr = 1; d_addr = 16'h0055; d_wdata = 16'h0066;
      m_rdata = 16'h0077; m_done = 1; m_stall = 0; m_cachehit = 0; m_err = 1;
      busy = 0; own_d = 0; cur_wr = 0; e_err = 0; cyc = 0; starve = 0; pl = '0;
      e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0; i_pend = 0; d_pend = 0; d_cur = '0;
      rand_en = 0; gap_en = 0; stray_force = 0; rdata_fix_en = 0; rdata_fix = 0;
      cyc_cnt = 0; mreq_cnt = 0; order_n = 0; order = 0; prev_mreq = 0;
      i_req_cyc = -1; i_done_cyc = -1; d_req_cyc = -1; d_done_cyc = -1;
      #3;
      check("rst_m_rd", 32'(m_rd), 0);
      check("rst_m_wr", 32'(m_wr), 0);
      check("rst_i_done", 32'(i_done), 0);
      check("rst_d_done", 32'(d_done), 0);
      check("rst_i_stall", 32'(i_stall), 1);
      check("rst_d_stall", 32'(d_stall), 1);
      check("rst_err", 32'(err), 0);
      check("rst_m_addr", 32'(m_addr), 0);
      check("rst_m_wdata", 32'(m_wdata), 0);
      check("rst_i_rdata", 32'(i_rdata), 0);
      check("rst_d_rdata", 32'(d_rdata), 0);
      @(posedge clk); #1;
      check("rst_err_hold", 32'(err), 0);
      i_rd = 0; d_rd = 0; d_wr = 0; m_done = 0; m_err = 0;
      @(posedge clk); #1;
      rst = 1;

      // Cache hit on a data read: done one cycle after the request.
      rdata_fix_en = 1; rdata_fix = 16'hBEEF;
      d_q.push_back('{op: 2'd0, addr: 16'h0040, wdata: 16'h0000});
      plan_q.push_back('{hit: 1'b1, n: 4'd0, w: 4'd1});
      drain();
      check("hit_latency", 32'(d_done_cyc - d_req_cyc), 1);
      check("hit_rdata", 32'(d_rdata), 32'hBEEF);
      rdata_fix_en = 0;

      // Fetch miss: 3 stall cycles, release, then done 2 cycles later.
      mreq_cnt = 0;
      i_addr_q.push_back(16'h0100);
      plan_q.push_back('{hit: 1'b0, n: 4'd3, w: 4'd2});
      drain();
      check("miss_mrd_cycles", 32'(mreq_cnt), 4);
      check("miss_latency", 32'(i_done_cyc - i_req_cyc), 6);
      check("miss_addr", 32'(m_addr), 32'h0100);

      // Contention: data wins LIMIT times, then the fetch, then data again.
      order = 0; order_n = 0;
      for (int k = 0; k < 5; k++) d_q.push_back('{op: 2'd1, addr: 16'h0200, wdata: 16'h1234});
      i_addr_q.push_back(16'h0300);
      for (int k = 0; k < 6; k++) plan_q.push_back('{hit: 1'b0, n: 4'd0, w: 4'd1});
      drain();
      check("cont_grants", 32'(order_n), 6);
      check("cont_order", 32'(order[5:0]), 32'b111101);
      check("cont_wdata", 32'(m_wdata), 32'h1234);

      // Illegal read+write: flagged, acknowledged, never issued, sticky.
      mreq_cnt = 0;
      d_q.push_back('{op: 2'd2, addr: 16'h0400, wdata: 16'h0000});
      drain();
      check("ill_no_access", 32'(mreq_cnt), 0);
      check("ill_done_same_cycle", 32'(d_done_cyc - d_req_cyc), 0);
      repeat (3) step();
      check("ill_err_sticky", 32'(err), 1);

      // Reset while waiting on a data read, then a stray m_done.
      d_q.push_back('{op: 2'd0, addr: 16'h0500, wdata: 16'h0000});
      plan_q.push_back('{hit: 1'b0, n: 4'd0, w: 4'd6});
      g = 0;
      while (!(busy && own_d && cyc == 2) && g < 20) begin step(); g++; end
      check("rst_reach_wait", 32'(g < 20), 1);
      rst = 0; #1;
      check("rstw_m_rd", 32'(m_rd), 0);
      check("rstw_m_wr", 32'(m_wr), 0);
      check("rstw_d_done", 32'(d_done), 0);
      check("rstw_d_stall", 32'(d_stall), 32'(d_rd | d_wr));
      check("rstw_err", 32'(err), 0);
      check("rstw_m_addr", 32'(m_addr), 0);
      check("rstw_d_rdata", 32'(d_rdata), 0);
      busy = 0; i_pend = 0; d_pend = 0; e_err = 0; starve = 0; cur_wr = 0;
      e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
      i_rd = 0; d_rd = 0; d_wr = 0; m_done = 0;
      @(posedge clk); #1;
      rst = 1;
      stray_force = 1; i_done_cyc = -1; d_done_cyc = -1;
      repeat (3) step();
      stray_force = 0;
      check("stray_no_i_done", 32'(i_done_cyc), 32'hFFFF_FFFF);
      check("stray_no_d_done", 32'(d_done_cyc), 32'hFFFF_FFFF);

      // Randomized traffic against the model.
      rand_en = 1; gap_en = 1;
      repeat (2000) step();
      rand_en = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch waits.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_rd in 1, i_addr in 16: fetch read request and address.
REQ-005 SHALL have ports i_rdata out 16, i_done out 1, i_stall out 1: fetch data, completion pulse, stall.
REQ-006 SHALL have ports d_rd in 1, d_wr in 1, d_addr in 16, d_wdata in 16: data-side request.
REQ-007 SHALL have ports d_rdata out 16, d_done out 1, d_stall out 1: data-side response.
REQ-008 SHALL have ports m_addr out 16, m_wdata out 16, m_rd out 1, m_wr out 1: shared stalling-memory request.
REQ-009 SHALL have ports m_rdata in 16, m_done in 1, m_stall in 1, m_cachehit in 1, m_err in 1: shared-memory response.
REQ-010 SHALL have port err out 1: sticky error flag.

Function
REQ-011 SHALL implement states IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D.
REQ-012 In IDLE, a data request (d_rd or d_wr) SHALL win over i_rd, except when starve_cnt equals STARVE_LIMIT and i_rd is high; the fetch then wins.
REQ-013 Grant SHALL register the winner's address and write data into m_addr/m_wdata and move to ISSUE_x.
REQ-014 IDLE with no request SHALL hold m_rd=m_wr=0 and stay in IDLE.
REQ-015 In ISSUE_x, m_rd (or m_wr for a data write) SHALL be 1 and the other 0.
REQ-016 In ISSUE_x with m_stall=1 and m_done=0, the block SHALL stay in ISSUE_x and keep asserting the request.
REQ-017 In ISSUE_x, m_done=1 (cache hit) SHALL complete the access immediately and move to IDLE.
REQ-018 In ISSUE_x, m_stall=0 and m_done=0 SHALL move to WAIT_x.
REQ-019 In WAIT_x, m_rd/m_wr SHALL be 0; m_done=1 SHALL complete the access and move to IDLE.
REQ-020 Completion SHALL pulse the owner's x_done for exactly that cycle, pass m_rdata to x_rdata that cycle, and register it.
REQ-021 x_rdata SHALL hold the registered value until the next completion for that requester.
REQ-022 Latency: a request seen in IDLE at cycle 0 issues at cycle 1; best-case done is cycle 1.
REQ-023 i_stall = i_rd & ~i_done and d_stall = (d_rd|d_wr) & ~d_done, both combinational.
REQ-024 Requesters SHALL hold request, address and data stable until x_done; the block samples them only in IDLE.
REQ-025 starve_cnt (3 bits, saturating): +1 on a data grant while i_rd=1; cleared on a fetch grant or when i_rd=0 in IDLE.
REQ-026 A data grant with d_rd=d_wr=1 SHALL set err, issue no access, pulse d_done with d_rdata unchanged, and stay in IDLE.
REQ-027 m_err=1 in any non-IDLE state SHALL set err; the access still completes on m_done.
REQ-028 m_done while in IDLE SHALL be ignored.
REQ-029 m_cachehit SHALL drive no control decision and is for debug only.

Reset
REQ-030 On rst=0, the block SHALL immediately reach state IDLE and m_rd=m_wr=0, abandoning any outstanding access.
REQ-031 On rst=0: m_addr, m_wdata, i_rdata, d_rdata = 16'h0000; starve_cnt = 0; err = 0.
REQ-032 On rst=0: i_done=d_done=0; i_stall/d_stall follow REQ-023 combinationally.
REQ-033 Reset release SHALL allow the first grant on the first rising edge with rst=1.

Structure
REQ-034 State encodings and the STARVE_LIMIT default SHALL live in the shared package mem_arb_pkg.
REQ-035 Grant selection SHALL be one sub-module, mem_arb_prio: combinational priority plus starvation override.
REQ-036 Implementation SHALL be one FSM process plus registered datapath, with no latches.

Verification
REQ-037 Hit: d_rd=1, d_addr=16'h0040, m_done=1 in ISSUE_D with m_rdata=16'hBEEF -> d_done pulses at cycle 1, d_rdata=16'hBEEF.
REQ-038 Miss: i_rd=1, i_addr=16'h0100, memory stall 3 cycles then done after 2 more -> m_rd high 4 cycles; i_done 6 cycles after request.
REQ-039 Contention: i_rd and d_wr held high, 16'h1234 to 16'h0200, every access 2 cycles -> data granted 4 times, then fetch, then data again.
REQ-040 Illegal request: d_rd=d_wr=1 -> err=1 next cycle, d_done pulses, no m_rd/m_wr; err stays 1 until rst=0.
REQ-041 Reset in WAIT_D -> m_rd=m_wr=0 and state IDLE immediately; a stray m_done after release gives no x_done.
